input_pack_mem: RTL
===================

INPUT_PACK_MEM -- requirements
Module: input_pack_mem

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 19200: number of 128-bit words written per frame.
REQ-002 SHALL have parameter DONE_DELAY, default 12: cycles from the last word's write strobe to the `done` assertion.
REQ-003 SHALL have port clock  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  level-sensitive frame enable; deassertion aborts the frame.
REQ-006 SHALL have port input_base_offset  input  1  buffer select; becomes WriteAddress[15] at frame start.
REQ-007 SHALL have port DataIn  input  8  pixel byte.
REQ-008 SHALL have port DataValid  input  1  DataIn valid this cycle.
REQ-009 SHALL have port DataReady  output  1  block accepts DataIn this cycle.
REQ-010 SHALL have port WriteAddress  output  16  memory word address.
REQ-011 SHALL have port WriteBus  output  128  packed word.
REQ-012 SHALL have port WriteEnable  output  1  one-cycle write strobe.
REQ-013 SHALL have port done  output  1  frame complete.

Function
REQ-014 SHALL implement a state machine with states IDLE, FILL, WRITE and DONE.
REQ-015 IDLE SHALL hold WriteAddress = {input_base_offset, 15'b0} and byte count = 0, and SHALL go to FILL when start = 1.
REQ-016 FILL SHALL drive DataReady = 1; a byte SHALL be accepted only in a cycle where DataValid = 1 and DataReady = 1.
REQ-017 The k-th accepted byte of a word (k = 0..15) SHALL be placed in WriteBus[127-8k -: 8]: the first byte goes to the MSBs.
REQ-018 On accepting byte 15, the block SHALL go to WRITE; in WRITE it SHALL drive WriteEnable = 1 and DataReady = 0 for exactly one cycle.
REQ-019 During the WriteEnable cycle, WriteBus SHALL be stable and WriteAddress SHALL be the address of that word.
REQ-020 After WRITE, WriteAddress[14:0] SHALL increment by 1, with bit 15 unchanged.
REQ-021 If the incremented count equals FRAME_WORDS, the block SHALL go to DONE; otherwise it SHALL go to FILL with byte count 0.
REQ-022 Entering DONE SHALL start a DONE_DELAY-cycle delay; `done` SHALL rise after exactly DONE_DELAY cycles and stay high while start = 1.
REQ-023 In DONE, DataReady SHALL be 0.
REQ-024 When start = 0, the block SHALL return to IDLE on the next edge from any state: the partial word is discarded, no write is issued, and `done` and the delay line are cleared.
REQ-025 Word-count arithmetic SHALL be 15 bits wide; FRAME_WORDS SHALL be <= 32767.
REQ-026 A DataValid that is high while DataReady = 0 SHALL be ignored; the byte is not consumed.

Reset
REQ-027 When reset_n = 0 at a clock edge, the block SHALL enter IDLE.
REQ-028 Reset SHALL force WriteAddress = 0, WriteBus = 0, WriteEnable = 0, DataReady = 0, done = 0, byte count = 0, and clear the done delay line.
REQ-029 Reset mid-frame SHALL abandon the frame without issuing a write.

Configuration
REQ-030 When INPUT_PACK_LSB_FIRST_EN is defined, byte k SHALL go to WriteBus[8k+7 -: 8] (first byte in the LSBs).
REQ-031 When INPUT_PACK_LSB_FIRST_EN is undefined, byte placement SHALL be MSB-first per REQ-017.

Structure
REQ-032 Package input_pack_pkg SHALL hold the state typedef, BYTES_PER_WORD = 16, and the ADDR_W = 16 and DATA_W = 128 constants.
REQ-033 Byte accumulation SHALL be implemented as sub-module input_pack_shift: byte in, load strobe, clear, 128-bit out, and byte-order selection by the macro.

Verification
REQ-034 Reset, then start = 1, base_offset = 1, and bytes 0x00..0x0F each with DataValid = 1 -> one WriteEnable; WriteAddress = 0x8000; WriteBus = 0x000102...0E0F.
REQ-035 Same stimulus with INPUT_PACK_LSB_FIRST_EN defined -> WriteBus = 0x0F0E...0100.
REQ-036 FRAME_WORDS = 3 with continuous DataValid -> writes at 0x0000, 0x0001 and 0x0002, each 17 cycles apart; `done` rises exactly 12 cycles after the third WriteEnable.
REQ-037 DataValid toggling 1010... -> bytes are accepted only on high cycles, and the word is identical to the gap-free case.
REQ-038 Start dropped after 7 bytes -> no WriteEnable; on restart, the first write is at the base address and contains only the new bytes.
REQ-039 reset_n = 0 for one cycle mid-word -> all outputs 0 on the next edge, and no write is issued.

Source files
------------

// File: rtl/input_pack_mem_pkg.sv
// Shared types and constants for the input byte packer.
package input_pack_pkg;
  localparam int BYTES_PER_WORD = 16;
  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 128;
  localparam int CNT_W          = 15;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
endpackage

// File: rtl/input_pack_mem_if.sv
// Byte-in / word-out handshake bundle for input_pack_mem.
interface input_pack_mem_if import input_pack_pkg::*; ();
  logic              start;
  logic              input_base_offset;
  logic [7:0]        DataIn;
  logic              DataValid;
  logic              DataReady;
  logic [ADDR_W-1:0] WriteAddress;
  logic [DATA_W-1:0] WriteBus;
  logic              WriteEnable;
  logic              done;

  modport slave (
    input  start, input_base_offset, DataIn, DataValid,
    output DataReady, WriteAddress, WriteBus, WriteEnable, done
  );

  modport master (
    output start, input_base_offset, DataIn, DataValid,
    input  DataReady, WriteAddress, WriteBus, WriteEnable, done
  );
endinterface

// File: rtl/input_pack_mem_shift.sv
// 16-byte accumulator; INPUT_PACK_LSB_FIRST_EN selects first byte in LSBs, else MSBs.
module input_pack_shift import input_pack_pkg::*; (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word
);
  logic [DATA_W-1:0] r_word;

  always_ff @(posedge clock) begin
    if (!reset_n || i_clear) begin
      r_word <= '0;
    end else if (i_load) begin
`ifdef INPUT_PACK_LSB_FIRST_EN
      r_word <= {i_byte, r_word[DATA_W-1:8]};
`else
      r_word <= {r_word[DATA_W-9:0], i_byte};
`endif
    end
  end

  assign o_word = r_word;
endmodule

// File: rtl/input_pack_mem.sv
// Packs a byte stream into 128-bit memory words, one frame per start; build option
// INPUT_PACK_LSB_FIRST_EN (in input_pack_shift) flips byte order within a word.
module input_pack_mem import input_pack_pkg::*; #(
  parameter int FRAME_WORDS = 19200,
  parameter int DONE_DELAY  = 12
) (
  input logic               clock,
  input logic               reset_n,
  input_pack_mem_if.slave   mem
);
  localparam int DLY_W = (DONE_DELAY < 2) ? 1 : $clog2(DONE_DELAY);
  localparam logic [DLY_W-1:0] DLY_LOAD  = DLY_W'(DONE_DELAY - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS);
  localparam logic [3:0]       LAST_BYTE = 4'(BYTES_PER_WORD - 1);

  state_t            r_state, w_next;
  logic [3:0]        r_bcnt;
  logic [CNT_W-1:0]  r_wcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DLY_W-1:0]  r_dly;
  logic              r_done;
  logic              w_accept, w_ready, w_we, w_last_word, w_clear;
  logic [CNT_W-1:0]  w_wcnt_inc;

  assign w_wcnt_inc  = r_wcnt + 1'b1;
  assign w_last_word = (w_wcnt_inc == LAST_WORD);
  assign w_clear     = (r_state == IDLE) || !mem.start;

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_we     = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      IDLE:  if (mem.start) w_next = FILL;
      FILL: begin
        w_ready  = 1'b1;
        w_accept = mem.DataValid;
        if (mem.DataValid && (r_bcnt == LAST_BYTE)) w_next = WRITE;
      end
      WRITE: begin
        w_we   = 1'b1;
        w_next = w_last_word ? DONE : FILL;
      end
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
    // Dropping start abandons whatever is in flight, including a partial word.
    if (!mem.start) begin
      w_next   = IDLE;
      w_accept = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_bcnt <= '0;
      r_wcnt <= '0;
      r_addr <= '0;
      r_dly  <= '0;
      r_done <= 1'b0;
    end else if (w_clear) begin
      r_bcnt <= '0;
      r_wcnt <= '0;
      r_addr <= {mem.input_base_offset, {(ADDR_W-1){1'b0}}};
      r_dly  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) r_bcnt <= r_bcnt + 1'b1;
      if (r_state == WRITE) begin
        r_addr[ADDR_W-2:0] <= r_addr[ADDR_W-2:0] + 1'b1;
        r_wcnt             <= w_wcnt_inc;
        if (w_last_word) begin
          if (DONE_DELAY <= 1) r_done <= 1'b1;
          else                 r_dly  <= DLY_LOAD;
        end
      end
      // Counter loaded on DONE entry; done rises DONE_DELAY cycles after the last strobe.
      if (r_state == DONE) begin
        if (r_dly == DLY_W'(1)) r_done <= 1'b1;
        if (r_dly != '0)        r_dly  <= r_dly - 1'b1;
      end
    end
  end

  input_pack_shift u_shift (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_accept),
    .i_clear (w_clear),
    .i_byte  (mem.DataIn),
    .o_word  (mem.WriteBus)
  );

  assign mem.DataReady    = w_ready;
  assign mem.WriteEnable  = w_we;
  assign mem.WriteAddress = r_addr;
  assign mem.done         = r_done;
endmodule
